// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser slice.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_HOLD    = 3'd5
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_code_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_timeout_ctr.sv
// Inter-byte gap counter: counts while enabled, restarts on clear, flags the last allowed cycle.
module uart_timeout_ctr #(
  parameter int unsigned LIMIT = 266
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] r_cnt;

  // A byte arriving in the final cycle clears the counter, so it beats the expiry.
  assign o_expire = i_enable && !i_clear && (r_cnt == W'(LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (!o_expire) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses SYNC/CMD/LEN/payload/XOR-checksum frames from a received-byte strobe and
// holds each good frame in a local buffer until the consumer acknowledges it.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE     = 1500000,
  parameter int unsigned CLOCK_FREQ    = 10000000,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk_int,
  input  logic          uart_reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          frm_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    frm_cmd,
  output logic [LW-1:0] frm_len,
  output logic          frm_done,
  output logic          frm_err,
  output logic [1:0]    err_code,
  output logic          ovr,
  output logic          busy,
  output parser_state_t dbg_state
);

  localparam int unsigned TIMEOUT_CYC =
    int'((64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLOCK_FREQ)) / 64'(BAUD_RATE));

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a held frame is
  // released by frm_ack, and bytes arriving while held are dropped and reported on ovr.

  parser_state_t r_state, w_next;
  err_code_t     r_err_code, w_err_code;
  logic          w_done, w_err, w_ovr;
  logic          r_frm_done, r_frm_err, r_ovr;
  logic [7:0]    r_frm_cmd;
  logic [LW-1:0] r_frm_len;
  logic [7:0]    r_csum;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_buf [0:MAX_LEN-1];
  logic          w_timed, w_expire;

  assign w_timed = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                   (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);

  uart_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .i_clk    (clk_int),
    .i_rst_n  (uart_reset),
    .i_clear  (rx_valid),
    .i_enable (w_timed),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next     = r_state;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_ovr      = 1'b0;
    w_err_code = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) w_next = ST_CMD;
      end
      ST_CMD: begin
        if (rx_valid) w_next = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid) begin
          if (rx_data > 8'(MAX_LEN)) begin
            w_next     = ST_IDLE;
            w_err      = 1'b1;
            w_err_code = ERR_LEN;
          end else if (rx_data == 8'd0) begin
            w_next = ST_CSUM;
          end else begin
            w_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid && (LW'(r_idx) == (r_frm_len - LW'(1)))) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_data == r_csum) begin
            w_next = ST_HOLD;
            w_done = 1'b1;
          end else begin
            w_next     = ST_IDLE;
            w_err      = 1'b1;
            w_err_code = ERR_CSUM;
          end
        end
      end
      ST_HOLD: begin
        w_ovr = rx_valid;
        if (frm_ack) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Expiry is only raised when no byte arrived, so it never collides with the cases above.
    if (w_expire) begin
      w_next     = ST_IDLE;
      w_err      = 1'b1;
      w_err_code = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      r_state    <= ST_IDLE;
      r_err_code <= ERR_NONE;
      r_frm_done <= 1'b0;
      r_frm_err  <= 1'b0;
      r_ovr      <= 1'b0;
      r_frm_cmd  <= '0;
      r_frm_len  <= '0;
      r_csum     <= '0;
      r_idx      <= '0;
    end else begin
      r_state    <= w_next;
      r_err_code <= w_err_code;
      r_frm_done <= w_done;
      r_frm_err  <= w_err;
      r_ovr      <= w_ovr;
      if (rx_valid) begin
        case (r_state)
          ST_CMD: begin
            r_frm_cmd <= rx_data;
            r_csum    <= rx_data;
          end
          ST_LEN: begin
            if (rx_data <= 8'(MAX_LEN)) begin
              r_frm_len <= rx_data[LW-1:0];
              r_csum    <= r_csum ^ rx_data;
              r_idx     <= '0;
            end
          end
          ST_PAYLOAD: begin
            r_csum <= r_csum ^ rx_data;
            r_idx  <= r_idx + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Payload storage is deliberately left without reset.
  always_ff @(posedge clk_int) begin
    if (rx_valid && r_state == ST_PAYLOAD) r_buf[r_idx] <= rx_data;
  end

  assign rd_data   = r_buf[rd_addr];
  assign frm_cmd   = r_frm_cmd;
  assign frm_len   = r_frm_len;
  assign frm_done  = r_frm_done;
  assign frm_err   = r_frm_err;
  assign err_code  = r_err_code;
  assign ovr       = r_ovr;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
